// File: rtl/fft16_frame_ctrl_if.sv
// Sample stream, FFT stage bus and bin stream of the 16-point frame sequencer.
// master: the controller; slave: source, stage and consumer seen from outside.
interface fft16_frame_ctrl_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [511:0] fft_data_flat;
  logic         fft_ready;
  logic         fft_done;
  logic [511:0] fft_real_flat;
  logic [511:0] fft_imag_flat;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_real;
  logic [31:0]  m_imag;
  logic [3:0]   m_index;
  logic         m_last;
  logic         busy;
  logic         err;
  logic [15:0]  frame_cnt;

  modport master (
    input  s_valid, s_data, fft_done, fft_real_flat, fft_imag_flat, m_ready,
    output s_ready, fft_data_flat, fft_ready, m_valid, m_real, m_imag,
           m_index, m_last, busy, err, frame_cnt
  );

  modport slave (
    output s_valid, s_data, fft_done, fft_real_flat, fft_imag_flat, m_ready,
    input  s_ready, fft_data_flat, fft_ready, m_valid, m_real, m_imag,
           m_index, m_last, busy, err, frame_cnt
  );
endinterface

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT stage: fill, launch, wait, drain.
// Define FFT16_CTRL_DIGITREV_EN to store samples in base-4 digit-reversed slots.
module fft16_frame_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  fft16_frame_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

  function automatic logic [3:0] slot_of(input logic [3:0] n);
`ifdef FFT16_CTRL_DIGITREV_EN
    return {n[1:0], n[3:2]};
`else
    return n;
`endif
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   in_cnt_q, in_cnt_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]   out_idx_q, out_idx_d;
  logic [511:0] frame_q, frame_d;
  logic [511:0] real_q, real_d;
  logic [511:0] imag_q, imag_d;
  logic         s_ready_q, s_ready_d;
  logic         fft_ready_q, fft_ready_d;
  logic         m_valid_q, m_valid_d;
  logic [31:0]  m_real_q, m_real_d;
  logic [31:0]  m_imag_q, m_imag_d;
  logic [3:0]   m_index_q, m_index_d;
  logic         m_last_q, m_last_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic         s_accept_s;
  logic         m_accept_s;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    out_idx_d   = out_idx_q;
    frame_d     = frame_q;
    real_d      = real_q;
    imag_d      = imag_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    s_accept_s  = (state_q == FILL) && s_ready_q && bus.s_valid;
    m_accept_s  = (state_q == DRAIN) && m_valid_q && bus.m_ready;

    case (state_q)
      FILL: begin
        if (s_accept_s) begin
          frame_d[{slot_of(in_cnt_q), 5'd0} +: 32] = bus.s_data;
          in_cnt_d = in_cnt_q + 4'd1;
          if (in_cnt_q == 4'd15) begin
            state_d = LAUNCH;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      LAUNCH: begin
        wait_cnt_d = 8'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (bus.fft_done) begin
          real_d    = bus.fft_real_flat;
          imag_d    = bus.fft_imag_flat;
          out_idx_d = 4'd0;
          state_d   = DRAIN;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          // Frame is dropped; the stage result, if it ever comes, is ignored.
          err_d   = 1'b1;
          state_d = FILL;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (m_accept_s) begin
          out_idx_d = out_idx_q + 4'd1;
          if (out_idx_q == 4'd15) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = FILL;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    // Outputs are registered from next state so they line up with the state register.
    s_ready_d   = (state_d == FILL);
    fft_ready_d = (state_d == LAUNCH);
    busy_d      = (state_d != FILL);
    m_valid_d   = (state_d == DRAIN);
    if (state_d == DRAIN) begin
      m_index_d = out_idx_d;
      m_last_d  = (out_idx_d == 4'd15);
      m_real_d  = real_d[{out_idx_d, 5'd0} +: 32];
      m_imag_d  = imag_d[{out_idx_d, 5'd0} +: 32];
    end else begin
      m_index_d = 4'd0;
      m_last_d  = 1'b0;
      m_real_d  = 32'd0;
      m_imag_d  = 32'd0;
    end
  end

  // State, buffers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      in_cnt_q    <= 4'd0;
      wait_cnt_q  <= 8'd0;
      out_idx_q   <= 4'd0;
      frame_q     <= 512'd0;
      real_q      <= 512'd0;
      imag_q      <= 512'd0;
      s_ready_q   <= 1'b0;
      fft_ready_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_real_q    <= 32'd0;
      m_imag_q    <= 32'd0;
      m_index_q   <= 4'd0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      out_idx_q   <= out_idx_d;
      frame_q     <= frame_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
      s_ready_q   <= s_ready_d;
      fft_ready_q <= fft_ready_d;
      m_valid_q   <= m_valid_d;
      m_real_q    <= m_real_d;
      m_imag_q    <= m_imag_d;
      m_index_q   <= m_index_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.s_ready       = s_ready_q;
  assign bus.fft_data_flat = frame_q;
  assign bus.fft_ready     = fft_ready_q;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_real        = m_real_q;
  assign bus.m_imag        = m_imag_q;
  assign bus.m_index       = m_index_q;
  assign bus.m_last        = m_last_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
  assign bus.frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Bench for fft16_frame_ctrl: 3-cycle stub stage, scoreboard of expected bins,
// directed frames covering launch timing, backpressure, timeout and mid-drain reset.
module tb_fft16_frame_ctrl;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic  clk;
  logic  rst;
  int    n_vec;
  int    n_bad;
  int    beats;
  bit    stub_en;
  logic [1:0] stub_cnt;
  logic [3:0] pat;
  beat_t sb[$];

  fft16_frame_ctrl_if bus();

  fft16_frame_ctrl #(.TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub stage: done two cycles after seeing the launch pulse, real = in, imag = -in.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt <= 2'd0;
    end else if (bus.fft_ready && stub_en) begin
      stub_cnt <= 2'd1;
    end else if (stub_cnt != 2'd0 && stub_cnt != 2'd3) begin
      stub_cnt <= stub_cnt + 2'd1;
    end else begin
      stub_cnt <= 2'd0;
    end
  end

  assign bus.fft_done = (stub_cnt == 2'd3);

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      bus.fft_real_flat[k*32 +: 32] = bus.fft_data_flat[k*32 +: 32];
      bus.fft_imag_flat[k*32 +: 32] = 32'd0 - bus.fft_data_flat[k*32 +: 32];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot_f(input int n);
`ifdef FFT16_CTRL_DIGITREV_EN
    return 4 * (n % 4) + n / 4;
`else
    return n;
`endif
  endfunction

  // Sample value that ends up in frame slot k when sample n carries base + n.
  function automatic logic [31:0] slot_val(input int k, input logic [31:0] base);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    for (int n = 0; n < 16; n++) begin
      if (slot_f(n) == k) v = base + 32'(n);
    end
    return v;
  endfunction

  task automatic push_frame(input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < 16; k++) begin
      b.re   = slot_val(k, base);
      b.im   = 32'd0 - b.re;
      b.idx  = 4'(k);
      b.last = (k == 15);
      sb.push_back(b);
    end
  endtask

  // Returns one time unit after the edge that accepted the 16th sample.
  task automatic send_frame(input logic [31:0] base);
    bit ok;
    bit got;
    for (int n = 0; n < 16; n++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = base + 32'(n);
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        ok = bus.s_ready;
        @(posedge clk);
        #1;
        got = ok;
      end
      if (!got) chk("sample_accept_timeout", 64'd0, 64'd1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input logic [15:0] exp_fc, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      bus.m_ready = toggle ? pat[i % 4] : 1'b1;
      @(posedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    chk({tag, "_drain_done"}, 64'(done), 64'd1);
    chk({tag, "_s_ready_after_last"}, 64'(bus.s_ready), 64'd1);
    chk({tag, "_m_valid_after_last"}, 64'(bus.m_valid), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(exp_fc));
    bus.m_ready = 1'b0;
  endtask

  // Scoreboard monitor: every presented bin must match the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (!rst && bus.m_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_bin", 64'(bus.m_index), 64'hFFFF);
      end else begin
        chk("m_real", 64'(bus.m_real), 64'(sb[0].re));
        chk("m_imag", 64'(bus.m_imag), 64'(sb[0].im));
        chk("m_index", 64'(bus.m_index), 64'(sb[0].idx));
        chk("m_last", 64'(bus.m_last), 64'(sb[0].last));
        chk("s_ready_in_drain", 64'(bus.s_ready), 64'd0);
        if (bus.m_ready) begin
          void'(sb.pop_front());
          beats++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    n_vec = 0;
    n_bad = 0;
    beats = 0;
    pat = 4'b1001;
    stub_en = 1'b1;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'd0;
    bus.m_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_fft_ready", 64'(bus.fft_ready), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_real", 64'(bus.m_real), 64'd0);
    chk("rst_m_index", 64'(bus.m_index), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("rst_fft_data", 64'(bus.fft_data_flat == 512'd0), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("s_ready_after_rst", 64'(bus.s_ready), 64'd1);

    // Frame A: samples 1..16, launch timing and slot placement
    push_frame(32'd1);
    send_frame(32'd1);
    chk("E0_fft_ready", 64'(bus.fft_ready), 64'd1);
    chk("E0_s_ready", 64'(bus.s_ready), 64'd0);
    chk("E0_busy", 64'(bus.busy), 64'd1);
    chk("slot4", 64'(bus.fft_data_flat[4*32 +: 32]), 64'(slot_val(4, 32'd1)));
    chk("slot1", 64'(bus.fft_data_flat[1*32 +: 32]), 64'(slot_val(1, 32'd1)));
    chk("slot15", 64'(bus.fft_data_flat[15*32 +: 32]), 64'd16);
    bus.m_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk("E1_fft_ready", 64'(bus.fft_ready), 64'd0);
      if (c < 4) chk("pre_E4_m_valid", 64'(bus.m_valid), 64'd0);
      else chk("E4_m_valid", 64'(bus.m_valid), 64'd1);
    end
    b0 = beats;
    drain(1'b0, 16'd1, "frameA");
    chk("frameA_beats", 64'(beats - b0), 64'd16);

    // Frame B: backpressure pattern 1,0,0,1
    push_frame(32'd100);
    send_frame(32'd100);
    b0 = beats;
    drain(1'b1, 16'd2, "frameB");
    chk("frameB_beats", 64'(beats - b0), 64'd16);

    // Timeout: stage never answers
    stub_en = 1'b0;
    send_frame(32'd50);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 15) begin
        chk("to_err_early", 64'(bus.err), 64'd0);
        chk("to_s_ready_early", 64'(bus.s_ready), 64'd0);
      end
      if (c == 16) begin
        chk("to_err", 64'(bus.err), 64'd1);
        chk("to_s_ready", 64'(bus.s_ready), 64'd1);
        chk("to_busy", 64'(bus.busy), 64'd0);
        chk("to_m_valid", 64'(bus.m_valid), 64'd0);
      end
    end
    stub_en = 1'b1;
    push_frame(32'd300);
    send_frame(32'd300);
    drain(1'b0, 16'd3, "frameC");
    chk("frameC_err_sticky", 64'(bus.err), 64'd1);

    // Reset while bin 7 is on the output
    push_frame(32'd1000);
    send_frame(32'd1000);
    bus.m_ready = 1'b1;
    b0 = 0;
    for (int i = 0; i < 200 && sb.size() != 9; i++) begin
      @(posedge clk);
      #1;
      b0 = i;
    end
    chk("bin7_reached", 64'(sb.size()), 64'd9);
    chk("bin7_index", 64'(bus.m_index), 64'd7);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("midrst_m_real", 64'(bus.m_real), 64'd0);
    chk("midrst_m_index", 64'(bus.m_index), 64'd0);
    chk("midrst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("midrst_err", 64'(bus.err), 64'd0);
    chk("midrst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_fft_data", 64'(bus.fft_data_flat == 512'd0), 64'd1);
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_s_ready_after", 64'(bus.s_ready), 64'd1);
    push_frame(32'd7);
    send_frame(32'd7);
    b0 = beats;
    drain(1'b0, 16'd1, "frameD");
    chk("frameD_beats", 64'(beats - b0), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
